// File: rtl/pool_tile_feeder_pkg.sv
// Shared definitions for the pooling tile feeder: default geometry, FSM states
// and helpers used to size counters and the downstream pooled output.
package pool_tile_feeder_pkg;

  localparam int IN_W_DEF  = 18;
  localparam int R_DEF     = 3;
  localparam int C_DEF     = 3;
  localparam int TILES_DEF = 4;

  // Geometry of the downstream max_pooling stage this feeder serves.
  localparam int R_P = 2;
  localparam int C_P = 2;
  localparam int S_P = 1;

  localparam int NUM_EL = R_DEF * C_DEF;
  localparam int CNT_W  = $clog2(NUM_EL);
  localparam int IDX_W  = $clog2(TILES_DEF);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    POOL = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Number of pooled values the downstream stage produces per tile.
  function automatic int pooled_count(input int r, input int c, input int rp,
                                      input int cp, input int s);
    return ((r - rp) / s + 1) * ((c - cp) / s + 1);
  endfunction

  // Counter width that stays legal (>= 1 bit) for degenerate sizes.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_tile_feeder_if.sv
// Serial pixel stream with valid/ready handshake into the tile feeder.
interface pool_tile_feeder_if #(
  parameter int In_W = 18
);
  logic            in_valid;
  logic [In_W-1:0] in_data;
  logic            in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/pool_tile_feeder_tile_buffer.sv
// Addressed register array holding one tile; element e sits at N[In_W*e +: In_W].
module pool_tile_feeder_tile_buffer #(
  parameter int In_W = 18,
  parameter int NUM  = 9,
  parameter int AW   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [In_W-1:0]     din,
  output logic [NUM*In_W-1:0] N
);

  logic [In_W-1:0] mem [NUM];

  // Write the addressed element; reset or soft clear wipes the whole tile.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      for (int e = 0; e < NUM; e++) mem[e] <= '0;
    end else if (we) begin
      for (int e = 0; e < NUM; e++) begin
        if (addr == AW'(e)) mem[e] <= din;
      end
    end
  end

  for (genvar g = 0; g < NUM; g++) begin : g_flat
    assign N[g*In_W +: In_W] = mem[g];
  end

endmodule

// File: rtl/pool_tile_feeder.sv
// Producer side of the pooling interface: gathers R x C samples into a tile,
// then strobes en_pool / en_pool_out and flags tile_done when Y is valid.
//
// state | meaning
// FILL  | accepting samples, cnt = next element to write
// POOL  | en_pool high, buffer frozen
// OUT   | en_pool_out high, buffer frozen
// DONE  | tile_done (and frame_done on last tile), tile_idx advances on exit
module pool_tile_feeder
  import pool_tile_feeder_pkg::*;
#(
  parameter int In_W  = IN_W_DEF,
  parameter int R     = R_DEF,
  parameter int C     = C_DEF,
  parameter int TILES = TILES_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  pool_tile_feeder_if.slave            s,
  output logic [In_W*R*C-1:0]          N,
  output logic                         en_pool,
  output logic                         en_pool_out,
  output logic                         tile_done,
  output logic [width_of(TILES)-1:0]   tile_idx,
  output logic                         frame_done
);

  localparam int NEL = R * C;
  localparam int CW  = width_of(NEL);
  localparam int IW  = width_of(TILES);
  localparam logic [CW-1:0] CNT_LAST = CW'(NEL - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(TILES - 1);

  state_t        state, nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [IW-1:0] idx_nx;
  logic          accept;
  logic          in_ready_q;

  assign s.in_ready = in_ready_q;

  // Next state, element counter and tile index.
  always_comb begin
    nx     = state;
    cnt_nx = cnt;
    idx_nx = tile_idx;
    accept = 1'b0;
    case (state)
      FILL: begin
        accept = s.in_valid && in_ready_q;
        if (accept) begin
          if (cnt == CNT_LAST) begin
            nx     = POOL;
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      POOL: nx = OUT;
      OUT:  nx = DONE;
      DONE: begin
        nx     = FILL;
        idx_nx = (tile_idx == IDX_LAST) ? '0 : tile_idx + IW'(1);
      end
      default: nx = FILL;
    endcase
  end

  // State register and counters; soft clear behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      state    <= FILL;
      cnt      <= '0;
      tile_idx <= '0;
    end else begin
      state    <= nx;
      cnt      <= cnt_nx;
      tile_idx <= idx_nx;
    end
  end

  // Moore outputs registered from the next state so they line up with state.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      in_ready_q  <= 1'b0;
      en_pool     <= 1'b0;
      en_pool_out <= 1'b0;
      tile_done   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      in_ready_q  <= (nx == FILL);
      en_pool     <= (nx == POOL);
      en_pool_out <= (nx == OUT);
      tile_done   <= (nx == DONE);
      frame_done  <= (nx == DONE) && (tile_idx == IDX_LAST);
    end
  end

  pool_tile_feeder_tile_buffer #(
    .In_W (In_W),
    .NUM  (NEL),
    .AW   (CW)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .we   (accept),
    .addr (cnt),
    .din  (s.in_data),
    .N    (N)
  );

endmodule
